// File: rtl/line_window_ctrl.sv
// Line buffer and K x K sliding-window generator with valid/ready handshakes on both sides.
// Optional zero padding at the line edges is enabled by defining LB_ZERO_PAD_EN.
module line_window_ctrl #(
    parameter int IMG_W = 512,
    parameter int PIX_W = 8,
    parameter int K     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [PIX_W-1:0]     i_pixel_data,
    input  logic                 i_pixel_valid,
    output logic                 o_pixel_ready,
    output logic [K*K*PIX_W-1:0] o_window,
    output logic                 o_window_valid,
    input  logic                 i_window_ready,
    output logic                 o_intr
);

    localparam int NBUF  = K + 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int SEL_W = $clog2(NBUF);
    localparam int AVL_W = $clog2(NBUF + 1);
`ifdef LB_ZERO_PAD_EN
    localparam int HALF     = K / 2;
    localparam int LAST_COL = IMG_W - 1;
`else
    localparam int LAST_COL = IMG_W - K;
`endif

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   wr_col_q, wr_col_d;
    logic [COL_W-1:0]   rd_col_q, rd_col_d;
    logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
    logic [SEL_W-1:0]   rd_sel_q, rd_sel_d;
    logic [AVL_W-1:0]   lines_avail_q, lines_avail_d;
    logic               intr_q, intr_d;

    logic               wr_en;
    logic               line_done;
    logic               row_done;

    logic [PIX_W-1:0]   line_mem [NBUF][IMG_W];

    logic [SEL_W:0]     tap_sel;
    logic [COL_W+1:0]   tap_col;
`ifdef LB_ZERO_PAD_EN
    logic [COL_W+1:0]   tap_idx;
`endif

    assign o_pixel_ready  = (lines_avail_q <= AVL_W'(K));
    assign o_window_valid = (state_q == S_READ);
    assign o_intr         = intr_q;

    always_comb begin
        wr_en     = i_pixel_valid && o_pixel_ready;
        line_done = wr_en && (wr_col_q == COL_W'(IMG_W - 1));
        row_done  = (state_q == S_READ) && i_window_ready && (rd_col_q == COL_W'(LAST_COL));

        wr_col_d      = wr_col_q;
        wr_sel_d      = wr_sel_q;
        rd_col_d      = rd_col_q;
        rd_sel_d      = rd_sel_q;
        state_d       = state_q;
        lines_avail_d = lines_avail_q;
        intr_d        = row_done;

        if (wr_en) begin
            wr_col_d = line_done ? '0 : wr_col_q + 1'b1;
        end
        if (line_done) begin
            wr_sel_d = (wr_sel_q == SEL_W'(NBUF - 1)) ? '0 : wr_sel_q + 1'b1;
        end

        // A line arriving in the same cycle a row retires leaves the count unchanged.
        case ({line_done, row_done})
            2'b10:   lines_avail_d = lines_avail_q + 1'b1;
            2'b01:   lines_avail_d = lines_avail_q - 1'b1;
            default: lines_avail_d = lines_avail_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (lines_avail_q >= AVL_W'(K)) begin
                    state_d  = S_READ;
                    rd_col_d = '0;
                end
            end
            S_READ: begin
                if (i_window_ready) begin
                    if (row_done) begin
                        state_d  = S_IDLE;
                        rd_sel_d = (rd_sel_q == SEL_W'(NBUF - 1)) ? '0 : rd_sel_q + 1'b1;
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            wr_col_q      <= '0;
            rd_col_q      <= '0;
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            lines_avail_q <= '0;
            intr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_col_q      <= wr_col_d;
            rd_col_q      <= rd_col_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            lines_avail_q <= lines_avail_d;
            intr_q        <= intr_d;
        end
    end

    // Line storage is deliberately not reset; lines_avail gates what is read.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            line_mem[wr_sel_q][wr_col_q] <= i_pixel_data;
        end
    end

    always_comb begin
        o_window = '0;
        tap_sel  = '0;
        tap_col  = '0;
`ifdef LB_ZERO_PAD_EN
        tap_idx  = '0;
`endif
        if (state_q == S_READ) begin
            for (int r = 0; r < K; r++) begin
                tap_sel = {1'b0, rd_sel_q} + (SEL_W + 1)'(r);
                if (tap_sel >= (SEL_W + 1)'(NBUF)) begin
                    tap_sel = tap_sel - (SEL_W + 1)'(NBUF);
                end
                for (int k = 0; k < K; k++) begin
                    tap_col = {2'b00, rd_col_q} + (COL_W + 2)'(k);
`ifdef LB_ZERO_PAD_EN
                    // Window is centred on rd_col; taps outside the line read as zero.
                    tap_idx = tap_col - (COL_W + 2)'(HALF);
                    if ((tap_col >= (COL_W + 2)'(HALF)) && (tap_idx <= (COL_W + 2)'(IMG_W - 1))) begin
                        o_window[(r*K+k)*PIX_W +: PIX_W] =
                            line_mem[tap_sel[SEL_W-1:0]][tap_idx[COL_W-1:0]];
                    end
`else
                    o_window[(r*K+k)*PIX_W +: PIX_W] =
                        line_mem[tap_sel[SEL_W-1:0]][tap_col[COL_W-1:0]];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Scoreboard bench for line_window_ctrl (IMG_W=8, K=3); follows LB_ZERO_PAD_EN when defined.
module tb_line_window_ctrl;

    localparam int IMG_W = 8;
    localparam int PIX_W = 8;
    localparam int K     = 3;
    localparam int WIN_W = K * K * PIX_W;
`ifdef LB_ZERO_PAD_EN
    localparam int WPR  = IMG_W;
    localparam bit PAD  = 1'b1;
`else
    localparam int WPR  = IMG_W - K + 1;
    localparam bit PAD  = 1'b0;
`endif

    typedef struct {
        logic [WIN_W-1:0] win;
        bit               last;
    } exp_t;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [PIX_W-1:0]   i_pixel_data = '0;
    logic               i_pixel_valid = 1'b0;
    logic               o_pixel_ready;
    logic [WIN_W-1:0]   o_window;
    logic               o_window_valid;
    logic               i_window_ready = 1'b0;
    logic               o_intr;

    line_window_ctrl #(.IMG_W(IMG_W), .PIX_W(PIX_W), .K(K)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pixel_data   (i_pixel_data),
        .i_pixel_valid  (i_pixel_valid),
        .o_pixel_ready  (o_pixel_ready),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .i_window_ready (i_window_ready),
        .o_intr         (o_intr)
    );

    always #5 i_clk = ~i_clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    exp_t             exp_q[$];
    logic [PIX_W-1:0] m_img [16][IMG_W];
    int               m_line, m_col, m_avail;
    int               acc_cnt, wr_cnt, intr_cnt;
    bit               exp_intr;
    bit               feed_done;
    int               rdy_mode = 0;
    logic [WIN_W-1:0] first_win;

    task automatic check_val(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIN_W-1:0] build_win(input int row, input int c);
        logic [WIN_W-1:0] w;
        int col;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                col = PAD ? c + k - K/2 : c + k;
                if (col >= 0 && col < IMG_W) begin
                    w[(r*K+k)*PIX_W +: PIX_W] = m_img[(row + r) % 16][col];
                end
            end
        end
        return w;
    endfunction

    // Window-ready driver: 0 = low, 1 = high, 2 = random
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                1:       i_window_ready = 1'b1;
                2:       i_window_ready = 1'($urandom_range(1, 0));
                default: i_window_ready = 1'b0;
            endcase
        end
    end

    // Monitor and scoreboard, sampled on the falling edge
    initial begin
        exp_t item;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                exp_q.delete();
                m_line = 0; m_col = 0; m_avail = 0;
                acc_cnt = 0; wr_cnt = 0; intr_cnt = 0;
                exp_intr = 1'b0;
            end else begin
                check_val("intr", WIN_W'(o_intr), WIN_W'(exp_intr));
                exp_intr = 1'b0;
                if (o_intr) intr_cnt++;
                check_val("pix_rdy", WIN_W'(o_pixel_ready), WIN_W'(m_avail <= K));
                if (!o_window_valid) begin
                    check_val("win_idle", o_window, '0);
                end else if (exp_q.size() == 0) begin
                    check_val("spurious_vld", WIN_W'(o_window_valid), '0);
                end else begin
                    check_val("window", o_window, exp_q[0].win);
                    if (i_window_ready) begin
                        item = exp_q.pop_front();
                        if (acc_cnt == 0) first_win = o_window;
                        acc_cnt++;
                        if (item.last) begin
                            exp_intr = 1'b1;
                            m_avail--;
                        end
                    end
                end
                if (i_pixel_valid && o_pixel_ready) begin
                    m_img[m_line % 16][m_col] = i_pixel_data;
                    wr_cnt++;
                    m_col++;
                    if (m_col == IMG_W) begin
                        m_col = 0;
                        m_line++;
                        m_avail++;
                        if (m_line >= K) begin
                            for (int c = 0; c < WPR; c++) begin
                                item.win  = build_win(m_line - K, c);
                                item.last = (c == WPR - 1);
                                exp_q.push_back(item);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic feed(input int n, input int base);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            i_pixel_data  = PIX_W'(base + i);
            i_pixel_valid = 1'b1;
            t = 0;
            do begin
                @(negedge i_clk);
                acc = o_pixel_ready;
                @(posedge i_clk);
                #1;
                t++;
            end while (!acc && t < 400);
            if (!acc) begin
                check_val("feed_timeout", WIN_W'(i), WIN_W'(n));
                break;
            end
        end
        i_pixel_valid = 1'b0;
    endtask

    task automatic run_feed(input int n, input int base);
        feed_done = 1'b0;
        fork
            begin
                feed(n, base);
                feed_done = 1'b1;
            end
        join_none
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || !feed_done) && t < budget) begin
            @(posedge i_clk);
            t++;
        end
        check_val("drain", WIN_W'(exp_q.size()), '0);
        check_val("feed_done", WIN_W'(feed_done), WIN_W'(1));
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_val("rst_vld", WIN_W'(o_window_valid), '0);
        check_val("rst_intr", WIN_W'(o_intr), '0);
        check_val("rst_win", o_window, '0);
        check_val("rst_rdy", WIN_W'(o_pixel_ready), WIN_W'(1));

        // 1: three lines, no stalls
        @(posedge i_clk);
        #1 rdy_mode = 1;
        run_feed(24, 0);
        wait_drain(200);
        check_val("t1_windows", WIN_W'(acc_cnt), WIN_W'(WPR));
        check_val("t1_intr", WIN_W'(intr_cnt), WIN_W'(1));
        check_val("t1_rdy", WIN_W'(o_pixel_ready), WIN_W'(1));
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                check_val($sformatf("t1_tap%0d%0d", r, k), WIN_W'(first_win[(r*K+k)*PIX_W +: PIX_W]),
                          PAD ? WIN_W'((k == 0) ? 0 : r*IMG_W + k - 1) : WIN_W'(r*IMG_W + k));
            end
        end

        // 2: five-cycle downstream stall mid-row
        do_reset();
        run_feed(24, 40);
        t = 0;
        while (acc_cnt < 3 && t < 200) begin
            @(posedge i_clk);
            t++;
        end
        rdy_mode = 0;
        repeat (5) @(posedge i_clk);
        rdy_mode = 1;
        wait_drain(200);
        check_val("t2_windows", WIN_W'(acc_cnt), WIN_W'(WPR));
        check_val("t2_intr", WIN_W'(intr_cnt), WIN_W'(1));

        // 3: input back-pressure with the window side stalled
        do_reset();
        rdy_mode = 0;
        run_feed(40, 0);
        repeat (60) @(posedge i_clk);
        @(negedge i_clk);
        check_val("t3_writes", WIN_W'(wr_cnt), WIN_W'(32));
        check_val("t3_rdy_low", WIN_W'(o_pixel_ready), '0);
        @(posedge i_clk);
        rdy_mode = 1;
        wait_drain(400);
        check_val("t3_total_wr", WIN_W'(wr_cnt), WIN_W'(40));
        check_val("t3_windows", WIN_W'(acc_cnt), WIN_W'(3 * WPR));
        check_val("t3_intr", WIN_W'(intr_cnt), WIN_W'(3));

        // 4: line completes in the same cycle a row retires; six lines wrap both selects
        do_reset();
        run_feed(48, 100);
        t = 0;
        do begin
            @(negedge i_clk);
            t++;
        end while (!o_window_valid && t < 200);
        rdy_mode = 0;
        @(posedge i_clk);
        @(posedge i_clk);
        rdy_mode = 1;
        wait_drain(400);
        check_val("t4_windows", WIN_W'(acc_cnt), WIN_W'(4 * WPR));
        check_val("t4_intr", WIN_W'(intr_cnt), WIN_W'(4));
        check_val("t4_rdy", WIN_W'(o_pixel_ready), WIN_W'(1));

        // 5: reset during READ at rd_col 3
        do_reset();
        run_feed(24, 0);
        t = 0;
        while (acc_cnt < 3 && t < 200) begin
            @(posedge i_clk);
            t++;
        end
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_val("t5_vld", WIN_W'(o_window_valid), '0);
        check_val("t5_intr", WIN_W'(o_intr), '0);
        check_val("t5_win", o_window, '0);
        check_val("t5_rdy", WIN_W'(o_pixel_ready), WIN_W'(1));
        repeat (12) @(posedge i_clk);
        #1;
        check_val("t5_no_intr", WIN_W'(intr_cnt), '0);

        // 6: random downstream readiness over six lines
        do_reset();
        rdy_mode = 2;
        run_feed(48, 7);
        wait_drain(800);
        check_val("t6_windows", WIN_W'(acc_cnt), WIN_W'(4 * WPR));
        check_val("t6_intr", WIN_W'(intr_cnt), WIN_W'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
